// File: rtl/nibble_serial_logic_unit_if.sv
// Request/response bundle for the nibble-serial logic unit.
// Master issues start/op/a/b; slave returns status and result.
interface nibble_serial_logic_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/nibble_serial_logic_unit.sv
// 32-bit bitwise logic unit evaluated one nibble per clock.
// Eight RUN cycles per operation, one-cycle done pulse.
module nibble_serial_logic_unit (
  input  logic clk,
  input  logic reset_n,
  nibble_serial_logic_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_n;
  logic [2:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic [31:0] res_n;
  logic        busy_q;
  logic        done_q;
  logic        zero_q;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [3:0]  y;
  logic [4:0]  base;
  logic        accept;

  assign accept = (state_q == IDLE) && bus.start;
  assign base   = {cnt_q, 2'b00};
  assign a_nib  = a_q[base +: 4];
  assign b_nib  = b_q[base +: 4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (cnt_q == 3'd7) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    y = 4'h0;
    unique case (1'b1)
      op_q == 3'b000: y = ~a_nib;
      op_q == 3'b001: y = a_nib & b_nib;
      op_q == 3'b010: y = a_nib | b_nib;
      op_q == 3'b011: y = a_nib ^ b_nib;
      op_q == 3'b100: y = ~(a_nib ^ b_nib);
      op_q == 3'b101: y = ~(a_nib & b_nib);
      default:        y = 4'h0;
    endcase
  end

  // zero must see nibble 7 as it is being written
  always_comb begin
    res_n = res_q;
    res_n[base +: 4] = y;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 3'd0;
      op_q   <= 3'b000;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      res_q  <= 32'h0;
      zero_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        op_q  <= bus.op;
        res_q <= 32'h0;
        cnt_q <= 3'd0;
      end else if (state_q == RUN) begin
        res_q <= res_n;
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          zero_q <= (res_n == 32'h0);
        end
      end
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_logic_unit.sv
// Directed bench for nibble_serial_logic_unit.
// Vector table plus reset, ignored-start and streaming sequences.
module tb_nibble_serial_logic_unit;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;
  int   done_cnt;

  nibble_serial_logic_unit_if bus ();

  nibble_serial_logic_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, " done seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    tick();
    bus.start = 1'b0;
    bus.op    = ~v.op;
    bus.a     = ~v.a;
    bus.b     = ~v.b;
    chk({v.name, " busy after accept"}, 32'(bus.busy), 32'd1);
    chk({v.name, " result cleared"}, bus.result, 32'h0);
    wait_done(v.name, lat);
    chk({v.name, " latency"}, lat, 32'd8);
    chk({v.name, " result"}, bus.result, v.res);
    chk({v.name, " zero"}, 32'(v.zero), 32'(bus.zero));
    tick();
    chk({v.name, " done one cycle"}, 32'(bus.done), 32'd0);
    chk({v.name, " busy idle"}, 32'(bus.busy), 32'd0);
    chk({v.name, " result held"}, bus.result, v.res);
  endtask

  initial begin
    int lat;
    int d0;
    int dn_t [$];
    int low_n;
    int low_pair;
    logic prev_low;

    n_chk    = 0;
    n_fail   = 0;
    done_cnt = 0;

    vecs[0] = '{"XOR",   3'b011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[1] = '{"NAND",  3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[2] = '{"INV",   3'b000, 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 1'b0};
    vecs[3] = '{"XNOR",  3'b100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{"OP111", 3'b111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1};
    vecs[5] = '{"AND",   3'b001, 32'h12345678, 32'hFF00FF00, 32'h12005600, 1'b0};
    vecs[6] = '{"OR",    3'b010, 32'h0F0F0000, 32'h00F000F0, 32'h0FFF00F0, 1'b0};
    vecs[7] = '{"OP110", 3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[8] = '{"XORZ",  3'b011, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b1};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    reset_n   = 1'b0;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset zero", 32'(bus.zero), 32'd0);
    chk("reset result", bus.result, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // XOR with first-nibble visibility after E1
    bus.start = 1'b1;
    bus.op    = 3'b011;
    bus.a     = 32'hFFFF0000;
    bus.b     = 32'h0F0F0F0F;
    tick();
    bus.start = 1'b0;
    tick();
    chk("xor nibble0", bus.result, 32'h0000000F);
    wait_done("xor seq", lat);
    chk("xor seq latency", lat, 32'd7);
    chk("xor seq result", bus.result, 32'hF0F00F0F);
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // reset in the middle of an AND
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.a     = 32'hFFFFFFFF;
    bus.b     = 32'hFFFFFFFF;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort partial", bus.result, 32'h00000FFF);
    d0 = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort zero", 32'(bus.zero), 32'd0);
    chk("abort result", bus.result, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("abort no done", done_cnt - d0, 32'd0);
    run_vec(vecs[0]);

    // start ignored while RUN and DONE
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.a     = 32'h12345678;
    bus.b     = 32'hFF00FF00;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.a     = 32'h00000000;
    bus.b     = 32'h00000000;
    tick();
    bus.start = 1'b0;
    wait_done("ign", lat);
    chk("ign result", bus.result, 32'h12005600);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign busy after done", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("ign single done", done_cnt - d0, 32'd1);
    chk("ign still idle", 32'(bus.busy), 32'd0);
    chk("ign result held", bus.result, 32'h12005600);

    // start held high: one op per 10 cycles
    bus.start = 1'b1;
    bus.op    = 3'b011;
    bus.a     = 32'h0000FFFF;
    bus.b     = 32'h00FF00FF;
    low_n     = 0;
    low_pair  = 0;
    prev_low  = 1'b0;
    @(posedge clk);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn_t.push_back(j);
      if (bus.busy === 1'b0) begin
        low_n++;
        if (prev_low) low_pair++;
      end
      prev_low = (bus.busy === 1'b0);
    end
    bus.start = 1'b0;
    chk("stream done count", dn_t.size(), 32'd3);
    if (dn_t.size() == 3) begin
      chk("stream first done", dn_t[0], 32'd8);
      chk("stream spacing 1", dn_t[1] - dn_t[0], 32'd10);
      chk("stream spacing 2", dn_t[2] - dn_t[1], 32'd10);
    end
    chk("stream busy low count", low_n, 32'd3);
    chk("stream busy low run", low_pair, 32'd0);
    tick();
    wait_done("stream tail", lat);
    chk("stream result", bus.result, 32'h00FFFF00);
    tick();
    chk("stream idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_logic_unit.md
# nibble_serial_logic_unit

Sequential 32-bit bitwise logic unit that computes one 4-bit slice per clock, handling eight nibbles per operation. It is the area-reduced serial counterpart to the fully parallel 32-bit gate datapath: it uses a single 4-bit slice of each gate function, iterated under a small FSM. It sits beside the ALU as a multi-cycle logic engine with a start/done handshake toward the controlling sequencer.

## Interface
Parameters:
- none. Width is fixed at 32 bits, processed as 8 nibbles.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation select, latched on accept.
- a  in  32  operand A, latched on accept.
- b  in  32  operand B, latched on accept.
- busy  out  1  high while state ≠ IDLE.
- done  out  1  one-cycle pulse when result is complete.
- result  out  32  result register.
- zero  out  1  high when completed result == 0; valid with done, then held.

## Operation
- op encoding, per nibble i, with A_i = a[4i+3:4i]:
  - 000: y = ~A_i
  - 001: A_i & B_i
  - 010: A_i | B_i
  - 011: A_i ^ B_i
  - 100: ~(A_i ^ B_i)
  - 101: ~(A_i & B_i)
  - 110, 111: 4'h0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch a, b and op into internal registers.
  - Clear result to 0 and set the 3-bit counter cnt = 0.
  - Transition to RUN.
  - If start=0, hold all registers.
- RUN, each cycle:
  - result[4*cnt+3:4*cnt] ← f(op, A_cnt, B_cnt); cnt ← cnt+1.
  - After writing nibble 7 (cnt==7), transition to DONE.
  - Set zero ← (final 32-bit result == 0). Compute it from the completed value, including nibble 7 being written.
- DONE: assert done for exactly one cycle, then transition to IDLE.
- start is ignored in RUN and DONE; nothing queues. Changes on a, b or op after accept do not affect the operation in flight.
- result and zero hold their values in IDLE until the next accepted start.
- cnt wraps naturally 7→0; the wrap value is unused after leaving RUN.

## Timing
- Reset (reset_n=0, takes effect immediately, async) values:
  - state = IDLE, cnt = 0
  - busy = 0, done = 0, zero = 0
  - result = 32'h0
  - latched a, b = 0; latched op = 000
- Reset asserted mid-operation aborts it: no done pulse, and result is cleared.
- All outputs are registered; there is no combinational path from input to output.
- Cycle sequence, with start accepted at edge E0:
  - After E0: busy=1, result=0.
  - Edges E1..E8 write nibbles 0..7; nibble n becomes visible after E(n+1).
  - After E8: done=1, zero valid, result final.
  - After E9: done=0, busy=0, state back in IDLE.
- Latency is 8 cycles from the accept edge to done.
- Earliest next accept is E10, so back-to-back throughput is one operation per 10 cycles.
- A start held high continuously is re-accepted at every IDLE edge, giving one operation per 10 cycles.

## Test plan
- **Reset:** assert reset_n=0 mid-RUN (after 3 nibbles of AND) → outputs go to 0 immediately and no done pulse. Release reset, apply start → a clean operation follows.
- **XOR:** a=32'hFFFF0000, b=32'h0F0F0F0F, op=011 → done 8 cycles after accept, result=32'hF0F00F0F, zero=0. Check the intermediate result after E1 is 32'h0000000F.
- **NAND → zero:** a=32'hFFFFFFFF, b=32'hFFFFFFFF, op=101 → result=32'h00000000, zero=1, done high exactly one cycle.
- **Ignored start / input change:** start op=001 with a=32'h12345678, b=32'hFF00FF00. Pulse start again in RUN with different a and b, and in DONE → result=32'h12005600, a single done pulse, and no second operation begins until IDLE.
- **INV / XNOR / undefined op:**
  - op=000, a=32'h0000FFFF → result=32'hFFFF0000.
  - op=100, a=b=32'hA5A5A5A5 → result=32'hFFFFFFFF.
  - op=111 → result=0, zero=1.
- **Continuous start:** hold start=1 for 30 cycles → done pulses are spaced exactly 10 cycles apart, and busy is low for exactly one cycle between operations.
